// File: rtl/val2_gen_pipe.sv
// val2_gen_pipe: two-stage pipelined ARM shifter-operand (val2) generator.
//   Stage 1 registers the decoded operand fields; stage 2 performs the shift
//   and registers val2 / shift_carry. Valid/ready handshake on both sides.
// Optional feature macro: VAL2_GEN_REG_SHIFT_EN enables register-specified
//   shifts (amount from val_rs). When undefined, bit4=1 shifts pass val_rm
//   through with carry_in.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   mem_en, imm           load/store offset mode, immediate-rotate mode
//   shift_operand[11:0]   instruction bits [11:0]
//   val_rm[W-1:0]         Rm value
//   val_rs[7:0]           Rs[7:0], register shift amount
//   carry_in              current C flag
//   out_valid / out_ready output handshake
//   val2[W-1:0]           shifter operand
//   shift_carry           shifter carry-out
module val2_gen_pipe #(
   parameter int unsigned W     = 32,
   parameter int unsigned LOG_W = $clog2(W)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          mem_en,
   input  logic          imm,
   input  logic [11:0]   shift_operand,
   input  logic [W-1:0]  val_rm,
   input  logic [7:0]    val_rs,
   input  logic          carry_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  val2,
   output logic          shift_carry
);

`ifdef VAL2_GEN_REG_SHIFT_EN
   localparam bit RegShiftEn = 1'b1;
`else
   localparam bit RegShiftEn = 1'b0;
`endif

   localparam logic [7:0] W8 = 8'(W);

   typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} sh_t;

   // Stage 1 registers
   logic          s1_valid_q, s1_valid_d;
   logic          s1_mem_q, s1_imm_q, s1_cin_q;
   logic [11:0]   s1_op_q;
   logic [7:0]    s1_amt_q;
   logic [W-1:0]  s1_rm_q;

   // Stage 2 registers
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  val2_q, val2_d;
   logic          carry_q, carry_d;

   logic          load1, load2;

   // Handshake: stage 2 drains into the consumer, stage 1 refills behind it
   assign load2    = s1_valid_q && (!out_valid_q || out_ready);
   assign in_ready = !s1_valid_q || load2;
   assign load1    = in_valid && in_ready;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      out_valid_d = out_valid_q;
      if (load1)      s1_valid_d = 1'b1;
      else if (load2) s1_valid_d = 1'b0;
      if (load2)          out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;
   end

   // Stage 1 capture; register-shift amount is captured even when the feature
   // is disabled, stage 2 simply never uses it in that build
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_mem_q   <= 1'b0;
         s1_imm_q   <= 1'b0;
         s1_cin_q   <= 1'b0;
         s1_op_q    <= '0;
         s1_amt_q   <= '0;
         s1_rm_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (load1) begin
            s1_mem_q <= mem_en;
            s1_imm_q <= imm;
            s1_cin_q <= carry_in;
            s1_op_q  <= shift_operand;
            s1_amt_q <= shift_operand[4] ? val_rs : 8'({3'b000, shift_operand[11:7]});
            s1_rm_q  <= val_rm;
         end
      end
   end

   // Stage 2 shifter
   sh_t               sh_type;
   logic              reg_sh, rrx;
   logic [7:0]        amt_eff, asr_amt;
   logic [W:0]        lsl_ext, lsr_ext, asr_ext;
   logic [LOG_W-1:0]  ror_r, rot;
   logic [W-1:0]      ror_val, imm8, imm_val;

   always_comb begin
      sh_type = sh_t'(s1_op_q[6:5]);
      reg_sh  = s1_op_q[4];
      amt_eff = s1_amt_q;
      rrx     = 1'b0;
      // Immediate amount 0 encodes LSR/ASR #W and RRX
      if (!reg_sh && (s1_amt_q == 8'd0)) begin
         if (sh_type == SH_LSR || sh_type == SH_ASR) amt_eff = W8;
         if (sh_type == SH_ROR)                      rrx     = 1'b1;
      end
      // Extra bit holds the carry: bit W for LSL, bit 0 for LSR/ASR
      lsl_ext = {1'b0, s1_rm_q} << amt_eff;
      lsr_ext = {s1_rm_q, 1'b0} >> amt_eff;
      asr_amt = (amt_eff > W8) ? W8 : amt_eff;
      asr_ext = $signed({s1_rm_q, 1'b0}) >>> asr_amt;
      ror_r   = amt_eff[LOG_W-1:0];
      ror_val = W'({s1_rm_q, s1_rm_q} >> ror_r);
      rot     = LOG_W'({s1_op_q[11:8], 1'b0});
      imm8    = W'(s1_op_q[7:0]);
      imm_val = W'({imm8, imm8} >> rot);

      val2_d  = s1_rm_q;
      carry_d = s1_cin_q;
      if (s1_mem_q) begin
         val2_d  = W'(s1_op_q);
      end else if (s1_imm_q) begin
         val2_d  = imm_val;
         carry_d = (rot == '0) ? s1_cin_q : imm_val[W-1];
      end else if (reg_sh && !RegShiftEn) begin
         val2_d  = s1_rm_q;
      end else if (rrx) begin
         val2_d  = {s1_cin_q, s1_rm_q[W-1:1]};
         carry_d = s1_rm_q[0];
      end else if (amt_eff != 8'd0) begin
         case (sh_type)
            SH_LSL: begin val2_d = lsl_ext[W-1:0]; carry_d = lsl_ext[W]; end
            SH_LSR: begin val2_d = lsr_ext[W:1];   carry_d = lsr_ext[0]; end
            SH_ASR: begin val2_d = asr_ext[W:1];   carry_d = asr_ext[0]; end
            default: begin
               if (ror_r == '0) begin
                  val2_d  = s1_rm_q;
                  carry_d = s1_rm_q[W-1];
               end else begin
                  val2_d  = ror_val;
                  carry_d = ror_val[W-1];
               end
            end
         endcase
      end
   end

   // Stage 2 output register, held while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         val2_q      <= '0;
         carry_q     <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         if (load2) begin
            val2_q  <= val2_d;
            carry_q <= carry_d;
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign val2        = val2_q;
   assign shift_carry = carry_q;

endmodule

// File: tb/tb_val2_gen_pipe.sv
// Scoreboard bench for val2_gen_pipe (W=32). Inputs change 1ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_val2_gen_pipe;
   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid, in_ready, mem_en, imm, carry_in;
   logic [11:0]   shift_operand;
   logic [W-1:0]  val_rm, val2;
   logic [7:0]    val_rs;
   logic          out_valid, out_ready, shift_carry;

   typedef struct packed {
      logic         c;
      logic [W-1:0] v;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   int unsigned n_out   = 0;

   val2_gen_pipe #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mem_en(mem_en), .imm(imm), .shift_operand(shift_operand),
      .val_rm(val_rm), .val_rs(val_rs), .carry_in(carry_in),
      .out_valid(out_valid), .out_ready(out_ready), .val2(val2),
      .shift_carry(shift_carry)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every completed output transfer is checked against the queue head
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_output", 64'(val2), 64'hdead);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk($sformatf("out%0d", n_out), 64'({shift_carry, val2}), 64'({e.c, e.v}));
         end
         n_out++;
      end
   end

   task automatic set_in(input logic m, input logic i, input logic [11:0] op,
                         input logic [W-1:0] rm, input logic [7:0] rs, input logic cin);
      mem_en = m; imm = i; shift_operand = op; val_rm = rm; val_rs = rs; carry_in = cin;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operand set until accepted; the expected result enters the
   // scoreboard on acceptance
   task automatic send(input logic m, input logic i, input logic [11:0] op,
                       input logic [W-1:0] rm, input logic [7:0] rs, input logic cin,
                       input logic [W-1:0] ev, input logic ec);
      bit acc = 1'b0;
      int n = 0;
      set_in(m, i, op, rm, rs, cin);
      in_valid = 1'b1;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready;
         tick();
         n++;
      end
      in_valid = 1'b0;
      if (acc) sb_q.push_back('{c: ec, v: ev});
      else chk("accept_timeout", 64'(acc), 64'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      chk("drain", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] snap;
      bit           streak;
      int           idx;
      int           ones;
      bit           acc;

      in_valid = 1'b0;
      out_ready = 1'b1;
      set_in(1'b0, 1'b0, 12'h000, '0, 8'd0, 1'b0);
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_val2", 64'(val2), 64'd0);
      chk("rst_carry", 64'(shift_carry), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      tick();
      rst_n = 1'b1;
      tick();

      // Immediate rotate: 3 ROR 2; result visible in the second cycle after acceptance
      send(1'b0, 1'b1, 12'h103, 32'h0, 8'd0, 1'b0, 32'hC000_0000, 1'b1);
      chk("lat_cycle1", 64'(out_valid), 64'd0);
      tick();
      chk("lat_cycle2", 64'(out_valid), 64'd1);

      send(1'b0, 1'b0, 12'h020, 32'h8000_0001, 8'd0, 1'b0, 32'h0000_0000, 1'b1); // LSR #0
      send(1'b0, 1'b0, 12'h060, 32'h0000_0003, 8'd0, 1'b1, 32'h8000_0001, 1'b1); // RRX
      send(1'b0, 1'b0, 12'h0E0, 32'h0000_0003, 8'd0, 1'b1, 32'h8000_0001, 1'b1); // ROR #1
      send(1'b1, 1'b1, 12'hABC, 32'h1234_5678, 8'd0, 1'b1, 32'h0000_0ABC, 1'b1); // mem wins
      send(1'b0, 1'b1, 12'h0FF, 32'h0, 8'd0, 1'b1, 32'h0000_00FF, 1'b1);         // rot 0
      send(1'b0, 1'b0, 12'h200, 32'hF000_0001, 8'd0, 1'b0, 32'h0000_0010, 1'b1); // LSL #4
      send(1'b0, 1'b0, 12'h040, 32'h8000_0000, 8'd0, 1'b0, 32'hFFFF_FFFF, 1'b1); // ASR #0
      send(1'b0, 1'b0, 12'h240, 32'h8000_0010, 8'd0, 1'b1, 32'hF800_0001, 1'b0); // ASR #4
      send(1'b0, 1'b0, 12'h0A0, 32'h0000_0003, 8'd0, 1'b0, 32'h0000_0001, 1'b1); // LSR #1
      send(1'b0, 1'b0, 12'h010, 32'h0000_0001, 8'd0, 1'b1, 32'h0000_0001, 1'b1); // LSL Rs=0
`ifdef VAL2_GEN_REG_SHIFT_EN
      send(1'b0, 1'b0, 12'h010, 32'h0000_0001, 8'd32, 1'b0, 32'h0, 1'b1);
      send(1'b0, 1'b0, 12'h010, 32'h0000_0001, 8'd33, 1'b0, 32'h0, 1'b0);
      send(1'b0, 1'b0, 12'h050, 32'h7FFF_FFFF, 8'd40, 1'b1, 32'h0, 1'b0);
      send(1'b0, 1'b0, 12'h070, 32'h8000_0000, 8'd32, 1'b0, 32'h8000_0000, 1'b1);
      send(1'b0, 1'b0, 12'h030, 32'h0000_00F8, 8'd4, 1'b0, 32'h0000_000F, 1'b1);
`else
      send(1'b0, 1'b0, 12'h010, 32'h0000_0001, 8'd32, 1'b0, 32'h0000_0001, 1'b0);
      send(1'b0, 1'b0, 12'h010, 32'h0000_0001, 8'd33, 1'b1, 32'h0000_0001, 1'b1);
      send(1'b0, 1'b0, 12'h050, 32'h7FFF_FFFF, 8'd40, 1'b1, 32'h7FFF_FFFF, 1'b1);
      send(1'b0, 1'b0, 12'h070, 32'h8000_0000, 8'd32, 1'b0, 32'h8000_0000, 1'b0);
      send(1'b0, 1'b0, 12'h030, 32'h0000_00F8, 8'd4, 1'b0, 32'h0000_00F8, 1'b0);
`endif
      drain();

      // Back-to-back pushes into a stalled consumer: values 1..5 via imm rot 0
      out_ready = 1'b0;
      idx = 0;
      snap = '0;
      for (int c = 0; c < 6; c++) begin
         in_valid = (idx < 5);
         set_in(1'b0, 1'b1, 12'(idx + 1), 32'h0, 8'd0, 1'b0);
         @(negedge clk);
         acc = in_valid && in_ready;
         if (c == 2) snap = val2;
         tick();
         if (acc) begin
            sb_q.push_back('{c: 1'b0, v: W'(idx + 1)});
            idx++;
         end
      end
      chk("stalled_accepts", 64'(idx), 64'd2);
      chk("stalled_in_ready", 64'(in_ready), 64'd0);
      chk("stalled_out_valid", 64'(out_valid), 64'd1);
      chk("stalled_hold_val2", 64'(val2), 64'(snap));
      chk("stalled_head_val2", 64'(val2), 64'd1);

      out_ready = 1'b1;
      streak = 1'b1;
      for (int c = 0; c < 10; c++) begin
         in_valid = (idx < 5);
         set_in(1'b0, 1'b1, 12'(idx + 1), 32'h0, 8'd0, 1'b0);
         @(negedge clk);
         acc = in_valid && in_ready;
         if (c < 5) streak = streak & out_valid;
         tick();
         if (acc) begin
            sb_q.push_back('{c: 1'b0, v: W'(idx + 1)});
            idx++;
         end
      end
      in_valid = 1'b0;
      chk("stream_all_accepted", 64'(idx), 64'd5);
      chk("stream_no_bubble", 64'(streak), 64'd1);
      drain();

      // Asynchronous reset with both stages full
      out_ready = 1'b0;
      send(1'b0, 1'b1, 12'h0AA, 32'h0, 8'd0, 1'b0, 32'h0000_00AA, 1'b0);
      send(1'b0, 1'b1, 12'h0BB, 32'h0, 8'd0, 1'b0, 32'h0000_00BB, 1'b0);
      tick();
      chk("pre_reset_valid", 64'(out_valid), 64'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(out_valid), 64'd0);
      chk("async_rst_val2", 64'(val2), 64'd0);
      sb_q.delete();
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      ones = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (out_valid) ones++;
         tick();
      end
      chk("post_reset_no_stale", 64'(ones), 64'd0);
      send(1'b0, 1'b1, 12'h103, 32'h0, 8'd0, 1'b0, 32'hC000_0000, 1'b1);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
